tb_irq_injector: RTL
====================

Name: tb_irq_injector

Overview:
- Synthesizable stimulus block that drives randomized external, software and timer interrupt requests into the E203 SoC under test.
- Sits directly upstream of the subsystem's plic_ext_irq, clint_sft_irq and clint_tmr_irq nets.
- Watches the committed-instruction PC stream to decide when to start injecting and when each interrupt has been handled.
- Replaces free-running testbench processes with a deterministic, seedable, countable engine.

Parameters:
- PC_W, 32, commit PC width (E203_PC_SIZE).
- PC_START, 32'h8000015C, PC that arms injection (after mtvec setup).
- PC_EXT_ACK, 32'h800000A6, handler PC that acknowledges the external IRQ.
- PC_SFT_ACK, 32'h800000BE, handler PC that acknowledges the software IRQ.
- PC_TMR_ACK, 32'h800000D6, handler PC that acknowledges the timer IRQ.
- DLY_W, 10, random delay width; delay range is 1..2^DLY_W.
- ACK_TMO, 65535, cycles in ASSERT before a channel gives up.
- CNT_W, 16, per-channel injection counter width.
- SEED_EXT, 16'hACE1, LFSR seed, external channel.
- SEED_SFT, 16'h1D2B, LFSR seed, software channel.
- SEED_TMR, 16'h5A5A, LFSR seed, timer channel.

Ports:
- clk  in  1  core clock (hfclk)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  injection enable; low freezes delay countdown
- stop_i  in  1  stop request (e.g. tohost count > 32)
- cmt_pc  in  PC_W  committed PC (alu_cmt_i_pc)
- cmt_pc_vld  in  1  committed PC valid
- ext_irq_o  out  1  external IRQ request
- sft_irq_o  out  1  software IRQ request
- tmr_irq_o  out  1  timer IRQ request
- ext_cnt_o  out  CNT_W  completed external injections
- sft_cnt_o  out  CNT_W  completed software injections
- tmr_cnt_o  out  CNT_W  completed timer injections
- armed_o  out  1  PC_START has been observed
- all_idle_o  out  1  no IRQ output asserted (combinational NOR of the three)
- timeout_o  out  1  sticky; any channel hit ACK_TMO

Behaviour:
- Reset values: all outputs 0; all_idle_o=1; all channels in IDLE; each LFSR loaded with its seed.
- A seed of 0 is replaced by 16'hACE1.
- Arming:
  - armed_o is set on the cycle after cmt_pc_vld && cmt_pc==PC_START.
  - It stays set until reset.
  - A matching PC is ignored unless cmt_pc_vld=1.
- LFSR:
  - 16-bit Galois, taps mask 16'hB400, shifts right every cycle regardless of state.
  - Delay load value = 1 + lfsr[DLY_W-1:0].
- Per-channel FSM, all channels independent and identical:
  - IDLE: when armed_o, load the delay counter and go to DELAY.
  - DELAY:
    - When en=1, decrement the counter. When en=0, hold.
    - When the counter equals 1 and en=1: go to ASSERT and register irq=1 on that edge.
    - Minimum gap from DELAY entry to irq high is therefore exactly the loaded delay in cycles.
  - ASSERT:
    - irq=1; the timeout counter increments each cycle.
    - en is ignored here; an asserted IRQ is never abandoned on en=0.
    - When cmt_pc_vld && cmt_pc==ACK_PC: irq=0 on the next edge, and cnt increments (saturating at all-ones).
      - If stop_i=1, go to STOP.
      - Otherwise load a new delay and go to DELAY.
    - If the timeout counter reaches ACK_TMO with no ack: irq=0, set timeout_o, go to STOP.
    - If ack and timeout occur in the same cycle, the ack wins.
  - STOP: irq=0 permanently until reset.
- stop_i is sampled only on ack; a stop never truncates an asserted IRQ.
- Handlers are not coordinated across channels: all three IRQs may be high simultaneously.
- Reset mid-operation:
  - All IRQ outputs drop asynchronously.
  - Counters clear and armed_o clears.
  - Injection restarts only after PC_START is seen again.

Decomposition:
- Package tb_irq_pkg holds:
  - channel state encoding (IDLE=2'd0, DELAY=2'd1, ASSERT=2'd2, STOP=2'd3);
  - LFSR tap mask 16'hB400 and the fallback seed 16'hACE1;
  - default PC constants.
- Sub-module tb_irq_chnl contains LFSR, delay counter, timeout counter, FSM and injection counter.
- tb_irq_injector contains only arming logic, three tb_irq_chnl instances, the timeout OR and all_idle_o.

Test Plan:
1. DLY_W=2, SEED_EXT=1, en=1; drive PC_START valid at cycle 10 -> armed_o=1 at cycle 11; ext_irq_o rises exactly (1+lfsr[1:0]) cycles after DELAY entry, within 1..4.
2. Drive PC_START with cmt_pc_vld=0 -> armed_o stays 0 and no IRQ ever asserts.
3. ext_irq_o high; present PC_EXT_ACK with vld=1 -> ext_irq_o=0 next cycle, ext_cnt_o 0->1; sft/tmr unaffected.
4. stop_i=1 when the third tmr ack arrives -> tmr_irq_o falls, tmr_cnt_o=3, the channel never reasserts over 5000 cycles.
5. ACK_TMO=16; withhold sft ack -> sft_irq_o falls after 16 ASSERT cycles, timeout_o=1 sticky, sft_cnt_o unchanged.
6. Deassert rst_n mid-ASSERT -> all IRQs 0 immediately, counters 0, all_idle_o=1; after release, no IRQ until PC_START is seen again.

Source files
------------

// File: rtl/tb_irq_pkg.sv
// Shared definitions for the interrupt injector: channel state encoding,
// LFSR constants, default PC constants and small helper functions.
package tb_irq_pkg;

    // Per-channel state encoding.
    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_DELAY  = 2'd1,
        CH_ASSERT = 2'd2,
        CH_STOP   = 2'd3
    } chnl_state_e;

    // 16-bit Galois LFSR, right-shifting.
    localparam logic [15:0] LFSR_TAPS          = 16'hB400;
    // An all-zero LFSR would lock up, so a zero seed is swapped for this one.
    localparam logic [15:0] LFSR_FALLBACK_SEED = 16'hACE1;

    // Default PCs matching the E203 interrupt test image.
    localparam logic [31:0] DEF_PC_START   = 32'h8000_015C;
    localparam logic [31:0] DEF_PC_EXT_ACK = 32'h8000_00A6;
    localparam logic [31:0] DEF_PC_SFT_ACK = 32'h8000_00BE;
    localparam logic [31:0] DEF_PC_TMR_ACK = 32'h8000_00D6;

    // Channel indices inside the injector.
    localparam int NUM_CHNL = 3;
    localparam int CH_EXT   = 0;
    localparam int CH_SFT   = 1;
    localparam int CH_TMR   = 2;

    // One step of the Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Replace a lock-up seed with the fallback seed.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? LFSR_FALLBACK_SEED : s;
    endfunction

endpackage

// File: rtl/tb_irq_chnl.sv
// One interrupt injection channel: free-running LFSR, random delay countdown,
// assert-until-acknowledged with a timeout, and a saturating injection count.
module tb_irq_chnl
    import tb_irq_pkg::*;
#(
    parameter int                PC_W    = 32,
    parameter logic [PC_W-1:0]   ACK_PC  = PC_W'(DEF_PC_EXT_ACK),
    parameter int                DLY_W   = 10,   // must not exceed 16 (LFSR width)
    parameter int                ACK_TMO = 65535,
    parameter int                CNT_W   = 16,
    parameter logic [15:0]       SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             armed,
    input  logic             en,
    input  logic             stop,
    input  logic [PC_W-1:0]  cmt_pc,
    input  logic             cmt_pc_vld,
    output logic             irq,
    output logic [CNT_W-1:0] cnt,
    output logic             timeout
);

    // Delay counter holds 1..2^DLY_W, so it needs one bit more than the LFSR slice.
    localparam int               CDW      = DLY_W + 1;
    // Timeout counter counts 0..ACK_TMO-1 while asserted.
    localparam int               TMO_W    = (ACK_TMO < 2) ? 1 : $clog2(ACK_TMO);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);
    localparam logic [15:0]      SEED_EFF = seed_fix(SEED);

    chnl_state_e       state_reg,   state_next;
    logic [15:0]       lfsr_reg,    lfsr_next;
    logic [CDW-1:0]    dly_reg,     dly_next;
    logic [TMO_W-1:0]  tmo_reg,     tmo_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic              timeout_reg, timeout_next;

    logic              ack_hit;
    logic [CDW-1:0]    dly_load;

    assign ack_hit  = cmt_pc_vld && (cmt_pc == ACK_PC);
    assign dly_load = CDW'(lfsr_reg[DLY_W-1:0]) + CDW'(1);

    // State register plus all counters; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= CH_IDLE;
            lfsr_reg    <= SEED_EFF;
            dly_reg     <= '0;
            tmo_reg     <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lfsr_reg    <= lfsr_next;
            dly_reg     <= dly_next;
            tmo_reg     <= tmo_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state and counter updates; the LFSR advances every cycle.
    always_comb begin
        state_next   = state_reg;
        lfsr_next    = lfsr_step(lfsr_reg);
        dly_next     = dly_reg;
        tmo_next     = tmo_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;

        case (state_reg)
            CH_IDLE: begin
                if (armed) begin
                    dly_next   = dly_load;
                    state_next = CH_DELAY;
                end
            end

            CH_DELAY: begin
                // Countdown only moves while enabled; reaching 1 raises irq on this edge.
                if (en) begin
                    if (dly_reg == CDW'(1)) begin
                        tmo_next   = '0;
                        state_next = CH_ASSERT;
                    end else begin
                        dly_next = dly_reg - CDW'(1);
                    end
                end
            end

            CH_ASSERT: begin
                // Ack beats timeout when both land on the same cycle; en is ignored here.
                if (ack_hit) begin
                    cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);
                    if (stop) begin
                        state_next = CH_STOP;
                    end else begin
                        dly_next   = dly_load;
                        state_next = CH_DELAY;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = CH_STOP;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end

            CH_STOP: begin
                // Parked until reset.
            end

            default: begin
                state_next = CH_IDLE;
            end
        endcase
    end

    // irq is a pure decode of the state register, so it drops with reset at once.
    assign irq     = (state_reg == CH_ASSERT);
    assign cnt     = cnt_reg;
    assign timeout = timeout_reg;

endmodule

// File: rtl/tb_irq_injector.sv
// Interrupt injector top: arms on the start PC, then runs three independent
// randomized channels for external, software and timer interrupts.
module tb_irq_injector
    import tb_irq_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] PC_START   = PC_W'(DEF_PC_START),
    parameter logic [PC_W-1:0] PC_EXT_ACK = PC_W'(DEF_PC_EXT_ACK),
    parameter logic [PC_W-1:0] PC_SFT_ACK = PC_W'(DEF_PC_SFT_ACK),
    parameter logic [PC_W-1:0] PC_TMR_ACK = PC_W'(DEF_PC_TMR_ACK),
    parameter int              DLY_W      = 10,
    parameter int              ACK_TMO    = 65535,
    parameter int              CNT_W      = 16,
    parameter logic [15:0]     SEED_EXT   = 16'hACE1,
    parameter logic [15:0]     SEED_SFT   = 16'h1D2B,
    parameter logic [15:0]     SEED_TMR   = 16'h5A5A
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             stop_i,
    input  logic [PC_W-1:0]  cmt_pc,
    input  logic             cmt_pc_vld,
    output logic             ext_irq_o,
    output logic             sft_irq_o,
    output logic             tmr_irq_o,
    output logic [CNT_W-1:0] ext_cnt_o,
    output logic [CNT_W-1:0] sft_cnt_o,
    output logic [CNT_W-1:0] tmr_cnt_o,
    output logic             armed_o,
    output logic             all_idle_o,
    output logic             timeout_o
);

    // Per-channel constants packed so the generate loop can slice them by index.
    localparam logic [NUM_CHNL*PC_W-1:0] ACK_PC_VEC = {PC_TMR_ACK, PC_SFT_ACK, PC_EXT_ACK};
    localparam logic [NUM_CHNL*16-1:0]   SEED_VEC   = {SEED_TMR, SEED_SFT, SEED_EXT};

    logic                armed_reg;
    logic [NUM_CHNL-1:0] irq_vec;
    logic [NUM_CHNL-1:0] tmo_vec;
    logic [CNT_W-1:0]    cnt_arr [NUM_CHNL];

    // Arm once the setup code commits the start PC; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_reg <= 1'b0;
        end else if (cmt_pc_vld && (cmt_pc == PC_START)) begin
            armed_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHNL; gi++) begin : g_chnl
            tb_irq_chnl #(
                .PC_W    (PC_W),
                .ACK_PC  (ACK_PC_VEC[gi*PC_W +: PC_W]),
                .DLY_W   (DLY_W),
                .ACK_TMO (ACK_TMO),
                .CNT_W   (CNT_W),
                .SEED    (SEED_VEC[gi*16 +: 16])
            ) u_chnl (
                .clk        (clk),
                .rst_n      (rst_n),
                .armed      (armed_reg),
                .en         (en),
                .stop       (stop_i),
                .cmt_pc     (cmt_pc),
                .cmt_pc_vld (cmt_pc_vld),
                .irq        (irq_vec[gi]),
                .cnt        (cnt_arr[gi]),
                .timeout    (tmo_vec[gi])
            );
        end
    endgenerate

    assign ext_irq_o  = irq_vec[CH_EXT];
    assign sft_irq_o  = irq_vec[CH_SFT];
    assign tmr_irq_o  = irq_vec[CH_TMR];
    assign ext_cnt_o  = cnt_arr[CH_EXT];
    assign sft_cnt_o  = cnt_arr[CH_SFT];
    assign tmr_cnt_o  = cnt_arr[CH_TMR];
    assign armed_o    = armed_reg;
    assign timeout_o  = |tmo_vec;
    assign all_idle_o = ~|irq_vec;

endmodule
